// File: rtl/status_bars_if.sv
// ============================================================================
//  Module      : status_bars_if
//  Description : Pixel-write bus from the status-bar renderer to the
//                frame-buffer writer (valid/ready handshake plus X/Y/colour).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface status_bars_if;
    logic       pix_valid;
    logic       pix_ready;
    logic [8:0] X;
    logic [7:0] Y;
    logic [6:0] color_index;

    modport master (
        output pix_valid,
        output X,
        output Y,
        output color_index,
        input  pix_ready
    );

    modport slave (
        input  pix_valid,
        input  X,
        input  Y,
        input  color_index,
        output pix_ready
    );
endinterface

`default_nettype wire

// File: rtl/status_bars.sv
// ============================================================================
//  Module      : status_bars
//  Description : Renders NUM_BARS framed, proportionally filled HUD bars as a
//                back-pressured pixel stream. Optional macro:
//                STATUS_BARS_LOW_WARN_EN (blinking low-value fill colour).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module status_bars #(
    parameter int         NUM_BARS    = 4,
    parameter int         VAL_W       = 7,
    parameter int         BAR_LEN     = 100,
    parameter int         HEIGHT      = 6,
    parameter int         START_X     = 40,
    parameter int         START_Y     = 10,
    parameter int         PITCH       = 10,
    parameter logic [6:0] FRAME_COLOR = 7'h7F,
    parameter logic [6:0] ALERT_COLOR = 7'b1010100
) (
    input  wire logic                      clk,
    input  wire logic                      rst_n,
    input  wire logic                      start_i,
    input  wire logic [NUM_BARS*VAL_W-1:0] values_i,
    input  wire logic [NUM_BARS*7-1:0]     fill_colors_i,
    input  wire logic [NUM_BARS-1:0]       alert_i,
    input  wire logic                      blink_i,
    status_bars_if.master                  pix,
    output logic                           busy_o,
    output logic                           done_o
);

    localparam int               BAR_W         = (NUM_BARS > 1) ? $clog2(NUM_BARS) : 1;
    localparam logic [8:0]       C_X0          = 9'(START_X);
    localparam logic [8:0]       C_X_LAST      = 9'(BAR_LEN + 1);
    localparam logic [7:0]       C_Y0          = 8'(START_Y);
    localparam logic [7:0]       C_Y_LAST      = 8'(HEIGHT + 1);
    localparam logic [7:0]       C_FILL_Y_LAST = 8'(HEIGHT - 1);
    localparam logic [BAR_W-1:0] C_LAST_BAR    = BAR_W'(NUM_BARS - 1);
    localparam logic [VAL_W-1:0] C_VAL_MAX     = VAL_W'(BAR_LEN);
`ifdef STATUS_BARS_LOW_WARN_EN
    localparam logic [VAL_W-1:0] C_WARN_LIM    = VAL_W'(BAR_LEN / 4);
    localparam logic [6:0]       C_WARN_COLOR  = 7'b1110000;
`endif

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FRAME = 2'd1,
        S_FILL  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [BAR_W-1:0]   bar_q, bar_d;
    logic [8:0]         x_q, x_d;
    logic [7:0]         y_q, y_d;
    logic [VAL_W-1:0]   val_q [NUM_BARS];
    logic [VAL_W-1:0]   val_d [NUM_BARS];
    logic [6:0]         col_q [NUM_BARS];
    logic [6:0]         col_d [NUM_BARS];
    logic [NUM_BARS-1:0] alert_q, alert_d;
    logic               valid_q, valid_d;
    logic [8:0]         X_q, X_d;
    logic [7:0]         Y_q, Y_d;
    logic [6:0]         color_q, color_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               w_accept;
    logic               w_emit;
    logic               w_row_end;
    logic               w_bar_end;
    logic [8:0]         w_cur_val;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            bar_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            val_q   <= '{default: '0};
            col_q   <= '{default: '0};
            alert_q <= '0;
            valid_q <= 1'b0;
            X_q     <= '0;
            Y_q     <= '0;
            color_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bar_q   <= bar_d;
            x_q     <= x_d;
            y_q     <= y_d;
            val_q   <= val_d;
            col_q   <= col_d;
            alert_q <= alert_d;
            valid_q <= valid_d;
            X_q     <= X_d;
            Y_q     <= Y_d;
            color_q <= color_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Counters track the pixel currently on the bus; the next pixel is
    // computed and registered only when the current one is accepted.
    always_comb begin
        state_d   = state_q;
        bar_d     = bar_q;
        x_d       = x_q;
        y_d       = y_q;
        val_d     = val_q;
        col_d     = col_q;
        alert_d   = alert_q;
        valid_d   = valid_q;
        X_d       = X_q;
        Y_d       = Y_q;
        color_d   = color_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        w_accept  = valid_q && pix.pix_ready;
        w_emit    = 1'b0;
        w_row_end = 1'b0;
        w_bar_end = 1'b0;
        w_cur_val = 9'(val_q[bar_q]);

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    for (int i = 0; i < NUM_BARS; i++) begin
                        val_d[i] = (values_i[i*VAL_W +: VAL_W] > C_VAL_MAX) ?
                                   C_VAL_MAX : values_i[i*VAL_W +: VAL_W];
                        col_d[i] = fill_colors_i[i*7 +: 7];
                    end
                    alert_d = alert_i;
                    bar_d   = '0;
                    x_d     = '0;
                    y_d     = '0;
                    busy_d  = 1'b1;
                    state_d = S_FRAME;
                    w_emit  = 1'b1;
                end
            end
            S_FRAME: begin
                if (w_accept) begin
                    w_emit = 1'b1;
                    if (y_q == 8'd0 || y_q == C_Y_LAST) begin
                        if (x_q != C_X_LAST) x_d = x_q + 9'd1;
                        else                 w_row_end = 1'b1;
                    end else if (x_q == 9'd0) begin
                        x_d = C_X_LAST;
                    end else begin
                        w_row_end = 1'b1;
                    end
                    if (w_row_end) begin
                        x_d = '0;
                        if (y_q != C_Y_LAST) begin
                            y_d = y_q + 8'd1;
                        end else if (w_cur_val != 9'd0) begin
                            state_d = S_FILL;
                            y_d     = '0;
                        end else begin
                            w_bar_end = 1'b1;
                        end
                    end
                end
            end
            S_FILL: begin
                if (w_accept) begin
                    w_emit = 1'b1;
                    if (x_q != w_cur_val - 9'd1) begin
                        x_d = x_q + 9'd1;
                    end else begin
                        x_d = '0;
                        if (y_q != C_FILL_Y_LAST) y_d = y_q + 8'd1;
                        else                      w_bar_end = 1'b1;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (w_bar_end) begin
            x_d = '0;
            y_d = '0;
            if (bar_q != C_LAST_BAR) begin
                bar_d   = bar_q + BAR_W'(1);
                state_d = S_FRAME;
            end else begin
                state_d = S_DONE;
                w_emit  = 1'b0;
                valid_d = 1'b0;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
        end

        if (w_emit) begin
            valid_d = 1'b1;
            Y_d     = C_Y0 + 8'(32'(bar_d) * PITCH) + y_d;
            if (state_d == S_FILL) begin
                X_d     = C_X0 + x_d + 9'd1;
                Y_d     = Y_d + 8'd1;
                color_d = col_d[bar_d];
`ifdef STATUS_BARS_LOW_WARN_EN
                if (val_d[bar_d] < C_WARN_LIM && blink_i) color_d = C_WARN_COLOR;
`endif
            end else begin
                X_d     = C_X0 + x_d;
                color_d = (alert_d[bar_d] && blink_i) ? ALERT_COLOR : FRAME_COLOR;
            end
        end
    end

    assign pix.pix_valid   = valid_q;
    assign pix.X           = X_q;
    assign pix.Y           = Y_q;
    assign pix.color_index = color_q;
    assign busy_o          = busy_q;
    assign done_o          = done_q;

endmodule

`default_nettype wire
